// File: rtl/hash_cmd_engine.sv
// hash_cmd_engine: UART command front end for a hash-search processor.
// Decodes byte commands (set hash, process payload, return match, status),
// forwards payload bytes to the processor and serialises replies to the UART.
module hash_cmd_engine #(
  parameter int HASH_BYTES     = 16,
  parameter int LEN_BYTES      = 2,
  parameter int MATCH_LEN      = 19,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rxd_data,
  input  logic                    rxd_data_ready,
  input  logic                    txd_busy,
  output logic                    txd_start,
  output logic [7:0]              txd_data,
  input  logic                    proc_done,
  input  logic                    proc_match,
  input  logic [8*LEN_BYTES-1:0]  proc_byte_pos,
  input  logic [7:0]              proc_match_char,
  output logic                    proc_start,
  output logic [8*LEN_BYTES-1:0]  proc_num_bytes,
  output logic [7:0]              proc_data,
  output logic                    proc_data_valid,
  output logic                    proc_match_char_next,
  output logic [8*HASH_BYTES-1:0] proc_target_hash,
  output logic [7:0]              leds
);

  localparam int HASH_W    = 8 * HASH_BYTES;
  localparam int LEN_W     = 8 * LEN_BYTES;
  localparam int CNT_MAX_A = (HASH_BYTES > MATCH_LEN) ? HASH_BYTES : MATCH_LEN;
  localparam int CNT_W_A   = $clog2(CNT_MAX_A + 1);
  // A length field of LEN_W bits never exceeds 2^LEN_W-1, so LEN_W bits hold it.
  localparam int CNT_W     = (CNT_W_A > LEN_W) ? CNT_W_A : LEN_W;
  localparam int GAP_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SET_HASH  = 4'd1,
    S_PROC_LEN  = 4'd2,
    S_PROC_DATA = 4'd3,
    S_PROC_WAIT = 4'd4,
    S_RET_POS   = 4'd5,
    S_RET_STR   = 4'd6,
    S_STATUS    = 4'd7,
    S_ACK       = 4'd8,
    S_NACK      = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [GAP_W-1:0]    gap_q, gap_d, gap_inc;
  logic [HASH_W-1:0]   hash_sh_q, hash_sh_d, hash_new;
  logic [HASH_W-1:0]   target_q, target_d;
  logic [LEN_W-1:0]    len_sh_q, len_sh_d, len_new;
  logic [LEN_W-1:0]    num_q, num_d;
  logic [LEN_W-1:0]    pos_sh;
  logic                start_q, start_d;
  logic [7:0]          pdata_q, pdata_d;
  logic                pvalid_q, pvalid_d;
  logic                char_q, char_d;
  logic                mnext_q, mnext_d;
  logic                txs_q, txs_d;
  logic                guard_q;
  logic [7:0]          txdat_q, txdat_d;
  logic                tsticky_q, tsticky_d;
  logic                lmatch_q, lmatch_d;
  logic                rx_state, gap_expired, tx_ok;

  // Transmit handshake: txd_start is a one-cycle strobe that carries txd_data,
  // and txd_data holds until the next strobe. The cycle after a strobe is
  // ignored (the UART may not have raised busy yet); after that a new strobe
  // is only issued from a cycle in which txd_busy was sampled low.
  assign tx_ok = !txs_q && !guard_q && !txd_busy;

  assign cnt_inc     = cnt_q + 1'b1;
  assign gap_inc     = gap_q + 1'b1;
  assign gap_expired = (gap_inc == GAP_W'(TIMEOUT_CYCLES));
  assign hash_new    = (hash_sh_q << 8) | HASH_W'(rxd_data);
  assign len_new     = (len_sh_q << 8) | LEN_W'(rxd_data);
  assign pos_sh      = proc_byte_pos << {cnt_q, 3'b000};
  assign rx_state    = (state_q == S_SET_HASH) || (state_q == S_PROC_LEN) ||
                       (state_q == S_PROC_DATA);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and next-value logic for every register of the engine.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = '0;
    hash_sh_d = hash_sh_q;
    target_d  = target_q;
    len_sh_d  = len_sh_q;
    num_d     = num_q;
    start_d   = 1'b0;
    pdata_d   = pdata_q;
    pvalid_d  = 1'b0;
    char_d    = 1'b0;
    mnext_d   = char_q;
    txs_d     = 1'b0;
    txdat_d   = txdat_q;
    tsticky_d = tsticky_q;
    lmatch_d  = lmatch_q;

    if (rx_state && !rxd_data_ready) gap_d = gap_inc;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rxd_data_ready) begin
          case (rxd_data)
            8'h01:   state_d = S_SET_HASH;
            8'h02:   state_d = S_PROC_LEN;
            8'h03:   state_d = S_RET_POS;
            8'h04:   state_d = S_STATUS;
            default: state_d = S_NACK;
          endcase
        end
      end
      S_SET_HASH: begin
        if (rxd_data_ready) begin
          hash_sh_d = hash_new;
          cnt_d     = cnt_inc;
          if (cnt_inc == CNT_W'(HASH_BYTES)) begin
            target_d = hash_new;
            cnt_d    = '0;
            state_d  = S_ACK;
          end
        end
      end
      S_PROC_LEN: begin
        if (rxd_data_ready) begin
          len_sh_d = len_new;
          cnt_d    = cnt_inc;
          if (cnt_inc == CNT_W'(LEN_BYTES)) begin
            num_d = len_new;
            cnt_d = '0;
            if (len_new == '0) begin
              state_d = S_NACK;
            end else begin
              start_d = 1'b1;
              state_d = S_PROC_DATA;
            end
          end
        end
      end
      S_PROC_DATA: begin
        if (rxd_data_ready) begin
          pdata_d  = rxd_data;
          pvalid_d = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == CNT_W'(num_q)) begin
            cnt_d   = '0;
            state_d = S_PROC_WAIT;
          end
        end
      end
      S_PROC_WAIT: begin
        if (proc_done) begin
          lmatch_d = proc_match;
          state_d  = proc_match ? S_ACK : S_NACK;
        end
      end
      S_RET_POS: begin
        if (tx_ok) begin
          txs_d   = 1'b1;
          txdat_d = pos_sh[LEN_W-1 -: 8];
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(LEN_BYTES)) begin
            cnt_d   = '0;
            state_d = S_RET_STR;
          end
        end
      end
      S_RET_STR: begin
        if (tx_ok) begin
          txs_d   = 1'b1;
          txdat_d = proc_match_char;
          char_d  = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == CNT_W'(MATCH_LEN)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_STATUS: begin
        if (tx_ok) begin
          txs_d     = 1'b1;
          txdat_d   = {6'b0, tsticky_q, lmatch_q};
          tsticky_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_ACK: begin
        if (tx_ok) begin
          txs_d   = 1'b1;
          txdat_d = 8'h01;
          state_d = S_IDLE;
        end
      end
      S_NACK: begin
        if (tx_ok) begin
          txs_d   = 1'b1;
          txdat_d = 8'h00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A payload gap that reaches the limit aborts the receive command.
    if (rx_state && !rxd_data_ready && gap_expired) begin
      tsticky_d = 1'b1;
      cnt_d     = '0;
      state_d   = S_NACK;
    end
  end

  // Datapath, strobe and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      gap_q     <= '0;
      hash_sh_q <= '0;
      target_q  <= '0;
      len_sh_q  <= '0;
      num_q     <= '0;
      start_q   <= 1'b0;
      pdata_q   <= '0;
      pvalid_q  <= 1'b0;
      char_q    <= 1'b0;
      mnext_q   <= 1'b0;
      txs_q     <= 1'b0;
      guard_q   <= 1'b0;
      txdat_q   <= '0;
      tsticky_q <= 1'b0;
      lmatch_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      hash_sh_q <= hash_sh_d;
      target_q  <= target_d;
      len_sh_q  <= len_sh_d;
      num_q     <= num_d;
      start_q   <= start_d;
      pdata_q   <= pdata_d;
      pvalid_q  <= pvalid_d;
      char_q    <= char_d;
      mnext_q   <= mnext_d;
      txs_q     <= txs_d;
      guard_q   <= txs_q;
      txdat_q   <= txdat_d;
      tsticky_q <= tsticky_d;
      lmatch_q  <= lmatch_d;
    end
  end

  assign txd_start            = txs_q;
  assign txd_data             = txdat_q;
  assign proc_start           = start_q;
  assign proc_num_bytes       = num_q;
  assign proc_data            = pdata_q;
  assign proc_data_valid      = pvalid_q;
  assign proc_match_char_next = mnext_q;
  assign proc_target_hash     = target_q;
  assign leds                 = {2'b00, tsticky_q, lmatch_q, state_q};

endmodule

// File: tb/tb_hash_cmd_engine.sv
// tb_hash_cmd_engine: directed bench with a UART reply scoreboard and a
// processor-side model for hash_cmd_engine.
module tb_hash_cmd_engine;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   rxd_data = 8'h00;
  logic         rxd_data_ready = 1'b0;
  logic         txd_busy;
  logic         txd_start;
  logic [7:0]   txd_data;
  logic         proc_done = 1'b0;
  logic         proc_match = 1'b0;
  logic [15:0]  proc_byte_pos = 16'h0000;
  logic [7:0]   proc_match_char;
  logic         proc_start;
  logic [15:0]  proc_num_bytes;
  logic [7:0]   proc_data;
  logic         proc_data_valid;
  logic         proc_match_char_next;
  logic [127:0] proc_target_hash;
  logic [7:0]   leds;

  logic [7:0] exp_q[$];
  logic [7:0] exp_pd_q[$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int busy_cnt = 0;
  logic busy_hold = 1'b0;
  int tx_cnt = 0;
  int start_cnt = 0;
  int pvalid_cnt = 0;
  int mnext_cnt = 0;
  int char_base = 0;

  assign txd_busy = busy_hold | (busy_cnt != 0);
  assign proc_match_char = 8'h41 + 8'(mnext_cnt - char_base);

  hash_cmd_engine #(
    .HASH_BYTES(16), .LEN_BYTES(2), .MATCH_LEN(19), .TIMEOUT_CYCLES(300)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready),
    .txd_busy(txd_busy), .txd_start(txd_start), .txd_data(txd_data),
    .proc_done(proc_done), .proc_match(proc_match),
    .proc_byte_pos(proc_byte_pos), .proc_match_char(proc_match_char),
    .proc_start(proc_start), .proc_num_bytes(proc_num_bytes),
    .proc_data(proc_data), .proc_data_valid(proc_data_valid),
    .proc_match_char_next(proc_match_char_next),
    .proc_target_hash(proc_target_hash), .leds(leds)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART side: scoreboard of transmitted bytes plus a busy model.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else if (txd_start) begin
      tx_cnt <= tx_cnt + 1;
      check("tx_while_busy", 128'(txd_busy), 128'(0));
      check("tx_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) check("tx_byte", 128'(txd_data), 128'(exp_q.pop_front()));
      busy_cnt <= 3;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Processor side: counts strobes and checks forwarded payload bytes.
  always @(negedge clk) begin
    if (reset_n) begin
      if (proc_start) start_cnt <= start_cnt + 1;
      if (proc_match_char_next) mnext_cnt <= mnext_cnt + 1;
      if (proc_data_valid) begin
        pvalid_cnt <= pvalid_cnt + 1;
        check("pd_expected", 128'(exp_pd_q.size() != 0), 128'(1));
        if (exp_pd_q.size() != 0) check("proc_data", 128'(proc_data), 128'(exp_pd_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rxd_data = b;
    rxd_data_ready = 1'b1;
    @(negedge clk);
    rxd_data_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (leds[3:0] == s) break;
    end
    check(tag, 128'(leds[3:0]), 128'(s));
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && leds[3:0] == 4'd0 && !txd_busy) break;
    end
    check(tag, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx"}, 128'({txd_start, txd_data}), 128'(0));
    check({tag, "_proc"}, 128'({proc_start, proc_num_bytes, proc_data,
                                proc_data_valid, proc_match_char_next}), 128'(0));
    check({tag, "_hash"}, proc_target_hash, 128'(0));
    check({tag, "_leds"}, 128'(leds), 128'(0));
  endtask

  task automatic proc_finish(input logic m);
    @(negedge clk);
    proc_done = 1'b1;
    proc_match = m;
    @(negedge clk);
    proc_done = 1'b0;
  endtask

  initial begin
    int snap_tx, snap_m, snap_s, snap_v;

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // SET_HASH with bytes 00..0F
    exp_q.push_back(8'h01);
    send_byte(8'h01);
    for (int i = 0; i < 15; i++) send_byte(8'(i));
    check("hash_not_early", proc_target_hash, 128'(0));
    send_byte(8'h0F);
    drain("set_ack", 200);
    check("hash_value", proc_target_hash, 128'h000102030405060708090A0B0C0D0E0F);

    // PROC "abc" with a match
    exp_pd_q.push_back(8'h61); exp_pd_q.push_back(8'h62); exp_pd_q.push_back(8'h63);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    check("num_bytes", 128'(proc_num_bytes), 128'(3));
    check("start_once", 128'(start_cnt), 128'(1));
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    wait_state("in_wait", 4'd4, 20);
    send_byte(8'h01);
    check("wait_discard", 128'(leds[3:0]), 128'(4));
    check("pvalid_cnt", 128'(pvalid_cnt), 128'(3));
    exp_q.push_back(8'h01);
    proc_finish(1'b1);
    drain("proc_ack", 200);
    check("last_match_1", 128'(leds[4]), 128'(1));

    // PROC repeat, no match
    exp_pd_q.push_back(8'h61); exp_pd_q.push_back(8'h62); exp_pd_q.push_back(8'h63);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    wait_state("in_wait2", 4'd4, 20);
    exp_q.push_back(8'h00);
    proc_finish(1'b0);
    drain("proc_nack", 200);
    check("last_match_0", 128'(leds[4]), 128'(0));
    check("start_twice", 128'(start_cnt), 128'(2));

    // PROC with N=0, then unknown command
    exp_q.push_back(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    drain("n0_nack", 200);
    check("n0_no_start", 128'(start_cnt), 128'(2));
    exp_q.push_back(8'h00);
    send_byte(8'h7F);
    drain("unknown_nack", 200);

    // RET with busy held high for 50 cycles
    char_base = mnext_cnt;
    proc_byte_pos = 16'h1234;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    for (int i = 0; i < 19; i++) exp_q.push_back(8'(8'h41 + i));
    snap_tx = tx_cnt;
    busy_hold = 1'b1;
    send_byte(8'h03);
    repeat (50) @(negedge clk);
    check("busy_hold_quiet", 128'(tx_cnt - snap_tx), 128'(0));
    busy_hold = 1'b0;
    drain("ret_drain", 800);
    repeat (20) @(negedge clk);
    check("ret_tx_count", 128'(tx_cnt - snap_tx), 128'(21));
    check("ret_mnext", 128'(mnext_cnt - char_base), 128'(19));

    // Timeout: N=5 with only 2 data bytes
    exp_pd_q.push_back(8'h78); exp_pd_q.push_back(8'h79);
    exp_q.push_back(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h78); send_byte(8'h79);
    drain("timeout_nack", 1000);
    check("timeout_sticky", 128'(leds[5]), 128'(1));
    check("timeout_start", 128'(start_cnt), 128'(3));
    exp_q.push_back(8'h02);
    send_byte(8'h04);
    drain("status_drain", 200);
    check("sticky_cleared", 128'(leds[5]), 128'(0));

    // Reset during RET_STR
    char_base = mnext_cnt;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    for (int i = 0; i < 19; i++) exp_q.push_back(8'(8'h41 + i));
    send_byte(8'h03);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (leds[3:0] == 4'd6 && (mnext_cnt - char_base) >= 3) break;
    end
    check("in_ret_str", 128'(leds[3:0]), 128'(6));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    snap_tx = tx_cnt; snap_m = mnext_cnt; snap_s = start_cnt; snap_v = pvalid_cnt;
    repeat (30) @(negedge clk);
    check("post_reset_quiet", 128'({32'(tx_cnt - snap_tx), 32'(mnext_cnt - snap_m),
                                    32'(start_cnt - snap_s), 32'(pvalid_cnt - snap_v)}), 128'(0));
    check("post_reset_idle", 128'(leds), 128'(0));
    exp_q.push_back(8'h00);
    send_byte(8'h04);
    drain("post_reset_status", 200);
    check("post_reset_tx", 128'(tx_cnt - snap_tx), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
